// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   - Port index constants: PORT_CPU is the load/store unit, PORT_DMA is the DMA/program loader.
//   - Default request/response field widths and memory depth.
//   - Response-slot state encoding used by dmem_rsp_slot.
package dmem_arb_pkg;

  localparam int NUM_PORTS     = 2;
  localparam int PORT_CPU      = 0;
  localparam int PORT_DMA      = 1;

  localparam int REQ_ADDR_W    = 32;
  localparam int REQ_DATA_W    = 32;
  localparam int DEF_MEM_WORDS = 256;

  // A response slot is either empty, or holding one response that the requester has not consumed yet
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for both arbiter ports.
// Each per-port field is indexed by port (0 = CPU, 1 = DMA).
//   req_valid/req_ready  request handshake (ready is the grant)
//   req_we/addr/wdata    request payload (byte address)
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata/rsp_err    response payload
// Modports: master = requester side, slave = arbiter side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = REQ_ADDR_W,
  parameter int DATA_W = REQ_DATA_W
);

  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS-1:0] req_ready;
  logic [NUM_PORTS-1:0] req_we;
  logic [ADDR_W-1:0]    req_addr  [NUM_PORTS];
  logic [DATA_W-1:0]    req_wdata [NUM_PORTS];

  logic [NUM_PORTS-1:0] rsp_valid;
  logic [NUM_PORTS-1:0] rsp_ready;
  logic [DATA_W-1:0]    rsp_rdata [NUM_PORTS];
  logic [NUM_PORTS-1:0] rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_rsp_slot.sv
// Single-entry response register for one arbiter port.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   load        a grant for this port happened this cycle; capture load_err/load_data
//   load_err    the granted access was rejected
//   load_data   read data for a legal load, zero otherwise
//   rsp_ready   requester consumes the held response
//   rsp_valid   response held
//   rsp_rdata   held read data
//   rsp_err     held error flag
module dmem_rsp_slot
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = REQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_err,
  input  logic [DATA_W-1:0] load_data,
  input  logic              rsp_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  // State register; reset drops any held response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state: a grant always (re)loads the slot, which gives back-to-back throughput when the
  // old response is consumed in the same cycle. The arbiter never grants a full slot that is not
  // being drained, so a load while FULL always replaces a consumed response.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          rdata_d = load_data;
          err_d   = load_err;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          state_d = SLOT_FULL;
          rdata_d = load_data;
          err_d   = load_err;
        end else if (rsp_ready) begin
          state_d = SLOT_EMPTY;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase
  end

  // Outputs come straight from the registers so the response is stable while held
  always_comb begin
    rsp_valid = (state_q == SLOT_FULL);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU load/store unit (port 0)
// and the DMA/program loader (port 1). One access per cycle, registered responses.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   bus         per-port request/response bundle (slave side)
//   mem_write   memory write enable
//   mem_addr    memory byte address
//   mem_wdata   memory write data
//   mem_rdata   memory combinational read data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = REQ_ADDR_W,
  parameter int DATA_W    = REQ_DATA_W,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // First byte address past the end of memory
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * MEM_WORDS);

  logic                 rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_any;
  logic                 gidx;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 legal;
  logic                 load_err;
  logic [DATA_W-1:0]    load_data;

  logic [NUM_PORTS-1:0] slot_valid;
  logic [NUM_PORTS-1:0] slot_err;
  logic [DATA_W-1:0]    slot_rdata [NUM_PORTS];

  // Round-robin pointer: names the port that wins the next contended cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Grant selection. A port may only be granted if its response slot is free or being drained
  // this cycle, so a stalled requester cannot block the other port. Nothing is granted in reset.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = bus.req_valid[i] & (~slot_valid[i] | bus.rsp_ready[i]);
    end
    grant = '0;
    if (!rst) begin
      if (&eligible) begin
        grant[PORT_CPU] = ~rr_ptr_q;
        grant[PORT_DMA] = rr_ptr_q;
      end else begin
        grant = eligible;
      end
    end
    grant_any     = |grant;
    gidx          = grant[PORT_DMA];
    rr_ptr_d      = grant_any ? ~gidx : rr_ptr_q;
    bus.req_ready = grant;
  end

  // Memory drive from the granted request. Misaligned or out-of-range accesses never write and
  // return zero data with the error flag set.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (grant_any) begin
      sel_we    = bus.req_we[gidx];
      sel_addr  = bus.req_addr[gidx];
      sel_wdata = bus.req_wdata[gidx];
    end
    legal     = (sel_addr[1:0] == 2'b00) && (sel_addr < ADDR_LIMIT);
    mem_write = grant_any & sel_we & legal;
    mem_addr  = sel_addr;
    mem_wdata = sel_wdata;
    load_err  = ~legal;
    load_data = (grant_any & legal & ~sel_we) ? mem_rdata : '0;
  end

  // One response slot per port; only the granted port's slot loads
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    dmem_rsp_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (grant[i]),
      .load_err  (load_err),
      .load_data (load_data),
      .rsp_ready (bus.rsp_ready[i]),
      .rsp_valid (slot_valid[i]),
      .rsp_rdata (slot_rdata[i]),
      .rsp_err   (slot_err[i])
    );
  end

  // Expose the slot contents on the response side of the bundle
  always_comb begin
    bus.rsp_valid = slot_valid;
    bus.rsp_err   = slot_err;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.rsp_rdata[i] = slot_rdata[i];
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 256-word memory attached.
// Expected responses are queued per port when a grant is expected and compared when the
// DUT presents them.
module tb_dmem_arbiter;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  logic        clk;
  logic        rst;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        load_mem;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  rsp_exp_t exp_q0[$];
  rsp_exp_t exp_q1[$];

  int  assert_count;
  int  fail_count;
  logic rst_prev;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_WORDS (256)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Clock generation: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int idx);
    return 32'hC0DE_0000 ^ (32'(idx) * 32'h0101_0101);
  endfunction

  function automatic logic is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr < 32'd1024);
  endfunction

  // Behavioural single-port memory: combinational read, write at the rising edge
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compare one port's response against the head of its scoreboard queue
  task automatic check_port(input int p, inout rsp_exp_t q[$]);
    check_value($sformatf("rsp_valid[%0d]", p), 32'(bus.rsp_valid[p]), 32'(q.size() != 0));
    if (q.size() != 0 && bus.rsp_valid[p] === 1'b1) begin
      check_value($sformatf("rsp_rdata[%0d]", p), bus.rsp_rdata[p], q[0].rdata);
      check_value($sformatf("rsp_err[%0d]", p), 32'(bus.rsp_err[p]), 32'(q[0].err));
      if (bus.rsp_ready[p]) void'(q.pop_front());
    end
    if (rst_prev) begin
      check_value($sformatf("reset rsp_rdata[%0d]", p), bus.rsp_rdata[p], 32'h0);
      check_value($sformatf("reset rsp_err[%0d]", p), 32'(bus.rsp_err[p]), 32'h0);
    end
  endtask

  // Per-cycle checks at the falling edge: responses from the previous edge, then this cycle's
  // grant and memory drive; the expected response of a grant is queued for the next cycle
  task automatic checkOutput(input logic [1:0] exp_grant);
    logic        g;
    logic        legal;
    logic        exp_write;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    rsp_exp_t    e;
    check_port(0, exp_q0);
    check_port(1, exp_q1);
    check_value("req_ready", 32'(bus.req_ready), 32'(exp_grant));
    exp_write = 1'b0;
    exp_addr  = 32'h0;
    exp_wdata = 32'h0;
    if (exp_grant != 2'b00) begin
      g         = exp_grant[1];
      legal     = is_legal(bus.req_addr[g]);
      exp_write = bus.req_we[g] & legal;
      exp_addr  = bus.req_addr[g];
      exp_wdata = bus.req_wdata[g];
      e.err     = ~legal;
      e.rdata   = (legal && !bus.req_we[g]) ? ref_mem[exp_addr[9:2]] : 32'h0;
      if (g) exp_q1.push_back(e);
      else   exp_q0.push_back(e);
      if (exp_write) ref_mem[exp_addr[9:2]] = exp_wdata;
    end
    check_value("mem_write", 32'(mem_write), 32'(exp_write));
    check_value("mem_addr", mem_addr, exp_addr);
    check_value("mem_wdata", mem_wdata, exp_wdata);
  endtask

  // Drive one cycle of inputs, check at the falling edge, advance past the rising edge
  task automatic applyStimulus(
    input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
    input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
    input logic r0, input logic r1, input logic [1:0] exp_grant, input logic reset_on
  );
    rst               = reset_on;
    bus.req_valid     = {v1, v0};
    bus.req_we        = {we1, we0};
    bus.req_addr[0]   = a0;
    bus.req_wdata[0]  = d0;
    bus.req_addr[1]   = a1;
    bus.req_wdata[1]  = d1;
    bus.rsp_ready     = {r1, r0};
    @(negedge clk);
    checkOutput(exp_grant);
    @(posedge clk);
    #1;
    rst_prev = reset_on;
    if (reset_on) begin
      exp_q0.delete();
      exp_q1.delete();
    end
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    rst_prev     = 1'b0;
    load_mem     = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    $display("[TB] reset");
    applyStimulus(0,0,32'h0,32'h0,        0,0,32'h0,32'h0,        0,0, 2'b00, 1);
    load_mem = 1'b0;
    applyStimulus(1,1,32'h10,32'h5555_5555, 1,1,32'h14,32'h6666_6666, 1,1, 2'b00, 1);

    $display("[TB] store then load on port 0");
    applyStimulus(1,1,32'h10,32'hDEAD_BEEF, 0,0,32'h0,32'h0,  1,1, 2'b01, 0);
    applyStimulus(1,0,32'h10,32'h0,         0,0,32'h0,32'h0,  1,1, 2'b01, 0);
    applyStimulus(0,0,32'h0,32'h0,          0,0,32'h0,32'h0,  1,1, 2'b00, 0);

    $display("[TB] round-robin alternation after reset");
    applyStimulus(0,0,32'h0,32'h0,          0,0,32'h0,32'h0,  1,1, 2'b00, 1);
    applyStimulus(1,0,32'h24,32'h0, 1,1,32'h24,32'hA5A5_0001, 1,1, 2'b01, 0);
    applyStimulus(1,0,32'h24,32'h0, 1,1,32'h24,32'hA5A5_0002, 1,1, 2'b10, 0);
    applyStimulus(1,0,32'h24,32'h0, 1,1,32'h24,32'hA5A5_0003, 1,1, 2'b01, 0);
    applyStimulus(1,0,32'h24,32'h0, 1,1,32'h24,32'hA5A5_0004, 1,1, 2'b10, 0);

    $display("[TB] port 1 stalled, port 0 keeps flowing");
    applyStimulus(1,0,32'h20,32'h0, 1,1,32'h28,32'hA5A5_0005, 1,0, 2'b01, 0);
    applyStimulus(1,0,32'h24,32'h0, 1,1,32'h28,32'hA5A5_0005, 1,0, 2'b01, 0);
    applyStimulus(1,0,32'h28,32'h0, 1,1,32'h28,32'hA5A5_0005, 1,0, 2'b01, 0);
    applyStimulus(1,0,32'h28,32'h0, 1,1,32'h28,32'hA5A5_0005, 1,1, 2'b10, 0);

    $display("[TB] illegal accesses");
    applyStimulus(1,1,32'h402,32'h1111_1111, 0,0,32'h0,32'h0, 1,1, 2'b01, 0);
    applyStimulus(1,1,32'h400,32'h2222_2222, 0,0,32'h0,32'h0, 1,1, 2'b01, 0);
    applyStimulus(1,0,32'h404,32'h0,         0,0,32'h0,32'h0, 1,1, 2'b01, 0);
    applyStimulus(1,0,32'h0,32'h0,           0,0,32'h0,32'h0, 1,1, 2'b01, 0);
    applyStimulus(1,0,32'h28,32'h0,          0,0,32'h0,32'h0, 1,1, 2'b01, 0);

    $display("[TB] reset with both responses pending");
    applyStimulus(1,1,32'h30,32'h3000_0001, 1,1,32'h34,32'h3400_0001, 1,1, 2'b10, 0);
    applyStimulus(1,1,32'h30,32'h3000_0002, 1,1,32'h34,32'h3400_0002, 1,0, 2'b01, 0);
    applyStimulus(1,1,32'h30,32'hBAD0_BAD0, 1,1,32'h34,32'hBAD0_BAD0, 0,0, 2'b00, 1);
    applyStimulus(1,0,32'h30,32'h0,         1,0,32'h34,32'h0,         1,1, 2'b01, 0);
    applyStimulus(1,0,32'h30,32'h0,         1,0,32'h34,32'h0,         1,1, 2'b10, 0);
    applyStimulus(0,0,32'h0,32'h0,          0,0,32'h0,32'h0,          1,1, 2'b00, 0);
    applyStimulus(0,0,32'h0,32'h0,          0,0,32'h0,32'h0,          1,1, 2'b00, 0);

    $display("[TB] memory contents");
    check_value("mem[0x000]", mem[0],  32'hC0DE_0000);
    check_value("mem[0x010]", mem[4],  32'hDEAD_BEEF);
    check_value("mem[0x024]", mem[9],  32'hA5A5_0004);
    check_value("mem[0x030]", mem[12], 32'h3000_0002);
    check_value("mem[0x034]", mem[13], 32'h3400_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
